bus_host_arb: RTL

BUS_HOST_ARB -- requirements
Module: bus_host_arb

---
 rtl/bus_host_arb_pkg.sv | 9 +
 rtl/bus_arb_id_fifo.sv | 62 ++++++
 rtl/bus_host_arb.sv | 133 +++++++++++++
 3 files changed

// File: rtl/bus_host_arb_pkg.sv
// Shared types for the bus host arbiter slice.
package bus_host_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/bus_arb_id_fifo.sv
// In-order FIFO of granted host IDs; supports push and pop in the same cycle, even when full.
module bus_arb_id_fifo #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy next-state; the counter saturates by construction.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    if (do_push && !do_pop)      count_d = count_q + CntW'(1);
    else if (do_pop && !do_push) count_d = count_q - CntW'(1);
  end

  // Pointer and counter registers, cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ID storage; contents are meaningless while empty so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/bus_host_arb.sv
// Round-robin arbiter merging NrHosts request ports onto one bus host port,
// with in-order routing of responses back to the originating host.
module bus_host_arb
  import bus_host_arb_pkg::*;
#(
  parameter int unsigned NrHosts        = 2,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NrHosts-1:0]                     host_req_i,
  output logic [NrHosts-1:0]                     host_gnt_o,
  input  logic [NrHosts-1:0][AddressWidth-1:0]   host_addr_i,
  input  logic [NrHosts-1:0]                     host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]    host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]      host_wdata_i,
  output logic [NrHosts-1:0]                     host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]      host_rdata_o,
  output logic [NrHosts-1:0]                     host_err_o,
  output logic                                   bus_req_o,
  output logic [AddressWidth-1:0]                bus_addr_o,
  output logic                                   bus_we_o,
  output logic [DataWidth/8-1:0]                 bus_be_o,
  output logic [DataWidth-1:0]                   bus_wdata_o,
  input  logic                                   bus_gnt_i,
  input  logic                                   bus_rvalid_i,
  input  logic [DataWidth-1:0]                   bus_rdata_i,
  input  logic                                   bus_err_i
);

  localparam int unsigned IdW = (NrHosts > 1) ? $clog2(NrHosts) : 1;

  arb_state_e     state_q, state_d;
  logic [IdW-1:0] ptr_q, ptr_d;
  logic [IdW-1:0] sel_q, sel_d;
  logic [IdW-1:0] rr_sel, sel;
  logic           fifo_full, fifo_empty;
  logic [IdW-1:0] fifo_head;
  logic           can_issue, push, pop;

  // Round-robin search for the first requester starting at the priority pointer.
  always_comb begin
    int unsigned idx;
    logic        found;
    rr_sel = ptr_q;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < NrHosts; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NrHosts) idx = idx - NrHosts;
      if (!found && host_req_i[idx]) begin
        found  = 1'b1;
        rr_sel = IdW'(idx);
      end
    end
  end

  assign sel = (state_q == LOCKED) ? sel_q : rr_sel;

  // A full FIFO can still accept when the head is being retired this cycle.
  assign can_issue = !fifo_full || bus_rvalid_i;
  assign bus_req_o = rst_ni && host_req_i[sel] && can_issue;
  assign push      = bus_req_o && bus_gnt_i;
  assign pop       = rst_ni && bus_rvalid_i && !fifo_empty;

  assign bus_addr_o  = host_addr_i[sel];
  assign bus_we_o    = host_we_i[sel];
  assign bus_be_o    = host_be_i[sel];
  assign bus_wdata_o = host_wdata_i[sel];

  // Grant and response-valid demultiplexing; read data and error are broadcast.
  always_comb begin
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    for (int unsigned i = 0; i < NrHosts; i++) begin
      host_gnt_o[i]    = push && (sel == IdW'(i));
      host_rvalid_o[i] = pop && (fifo_head == IdW'(i));
      host_rdata_o[i]  = bus_rdata_i;
      host_err_o[i]    = bus_err_i;
    end
  end

  // Next-state: lock onto a stalled request; the lock is held while the host keeps
  // requesting (even if a full FIFO masks bus_req_o) and drops on grant or withdrawal.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (push) ptr_d = (sel == IdW'(NrHosts - 1)) ? '0 : sel + IdW'(1);
    unique case (state_q)
      IDLE: begin
        if (bus_req_o && !bus_gnt_i) begin
          state_d = LOCKED;
          sel_d   = sel;
        end
      end
      LOCKED: begin
        if (push || !host_req_i[sel_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, priority pointer and locked selection registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
    end
  end

  bus_arb_id_fifo #(
    .Width (IdW),
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (sel),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

endmodule
